// File: rtl/clk_gate_idle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : clk_gate_idle_ctrl
// Description : Idle-detect clock-gating controller. Counts qualifying idle
//               cycles, raises a registered disable for a NOR-style gate cell
//               once a programmable threshold is reached, de-gates on
//               activity/wake/force, and acknowledges wake requests after the
//               gated clock has settled.
// Revision    : 1.0 - initial release
// ============================================================================
module clk_gate_idle_ctrl #(
    parameter int IDLE_W      = 8,
    parameter int WAKE_CYCLES = 2,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IDLE_W-1:0] idle_thresh,
    input  logic              busy,
    input  logic              wake_req,
    input  logic              force_on,
    output logic              clk_dis,
    output logic              wake_ack,
    output logic              gated,
    output logic [CNT_W-1:0]  gate_events
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_GATED = 2'd1,
        ST_WAKE  = 2'd2
    } state_t;

    localparam logic [3:0] c_WAKE_LAST = 4'(WAKE_CYCLES - 1);

    state_t            state_q;
    logic [IDLE_W-1:0] idle_cnt_q;
    logic [3:0]        wake_cnt_q;
    logic              ack_armed_q;
    logic              clk_dis_q;
    logic              wake_ack_q;
    logic              gated_q;
    logic [CNT_W-1:0]  gate_events_q;

    logic              q_idle;
    logic              thresh_hit;
    logic [IDLE_W:0]   idle_sum;
    logic [IDLE_W-1:0] idle_cnt_d;
    logic [CNT_W-1:0]  gate_events_d;

    // Idle qualification, threshold compare (one bit wider so a saturated
    // counter still compares correctly) and saturating increments.
    always_comb begin
        q_idle        = ~busy & ~wake_req & ~force_on & (idle_thresh != '0);
        idle_sum      = {1'b0, idle_cnt_q} + {{IDLE_W{1'b0}}, 1'b1};
        thresh_hit    = idle_sum >= {1'b0, idle_thresh};
        idle_cnt_d    = (&idle_cnt_q) ? idle_cnt_q : idle_sum[IDLE_W-1:0];
        gate_events_d = (&gate_events_q) ? gate_events_q
                                         : gate_events_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    // Gating FSM with all outputs registered; reset releases the clock at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_RUN;
            idle_cnt_q    <= '0;
            wake_cnt_q    <= '0;
            ack_armed_q   <= 1'b1;
            clk_dis_q     <= 1'b0;
            wake_ack_q    <= 1'b0;
            gated_q       <= 1'b0;
            gate_events_q <= '0;
        end else begin
            wake_ack_q <= 1'b0;
            if (!wake_req) begin
                ack_armed_q <= 1'b1;
            end

            case (state_q)
                ST_RUN: begin
                    // An ack can only be issued from RUN, so a request raised
                    // while gated is answered after the wake sequence.
                    if (wake_req && ack_armed_q) begin
                        wake_ack_q  <= 1'b1;
                        ack_armed_q <= 1'b0;
                    end
                    if (!q_idle) begin
                        idle_cnt_q <= '0;
                    end else if (thresh_hit) begin
                        state_q       <= ST_GATED;
                        clk_dis_q     <= 1'b1;
                        gated_q       <= 1'b1;
                        idle_cnt_q    <= '0;
                        gate_events_q <= gate_events_d;
                    end else begin
                        idle_cnt_q <= idle_cnt_d;
                    end
                end

                ST_GATED: begin
                    // Only real wake sources de-gate; a zeroed threshold does not.
                    if (busy || wake_req || force_on) begin
                        state_q    <= ST_WAKE;
                        clk_dis_q  <= 1'b0;
                        gated_q    <= 1'b0;
                        wake_cnt_q <= '0;
                    end
                end

                ST_WAKE: begin
                    // Fixed settle window; input changes cannot abort it.
                    if (wake_cnt_q == c_WAKE_LAST) begin
                        state_q    <= ST_RUN;
                        wake_cnt_q <= '0;
                        idle_cnt_q <= '0;
                    end else begin
                        wake_cnt_q <= wake_cnt_q + 4'd1;
                    end
                end

                default: begin
                    state_q   <= ST_RUN;
                    clk_dis_q <= 1'b0;
                    gated_q   <= 1'b0;
                end
            endcase
        end
    end

    assign clk_dis     = clk_dis_q;
    assign wake_ack    = wake_ack_q;
    assign gated       = gated_q;
    assign gate_events = gate_events_q;

endmodule
`default_nettype wire

// File: tb/tb_clk_gate_idle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_clk_gate_idle_ctrl
// Description : Directed self-checking bench for clk_gate_idle_ctrl
//               (IDLE_W=8, WAKE_CYCLES=2, CNT_W=4 to reach saturation).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clk_gate_idle_ctrl;

    localparam int c_IDLE_W = 8;
    localparam int c_WAKE   = 2;
    localparam int c_CNT_W  = 4;

    logic                clk;
    logic                rst;
    logic [c_IDLE_W-1:0] idle_thresh;
    logic                busy;
    logic                wake_req;
    logic                force_on;
    logic                clk_dis;
    logic                wake_ack;
    logic                gated;
    logic [c_CNT_W-1:0]  gate_events;

    int n_tests;
    int n_fail;
    int acc;

    clk_gate_idle_ctrl #(
        .IDLE_W      (c_IDLE_W),
        .WAKE_CYCLES (c_WAKE),
        .CNT_W       (c_CNT_W)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .idle_thresh (idle_thresh),
        .busy        (busy),
        .wake_req    (wake_req),
        .force_on    (force_on),
        .clk_dis     (clk_dis),
        .wake_ack    (wake_ack),
        .gated       (gated),
        .gate_events (gate_events)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance past n active edges; inputs are driven and outputs sampled 1 ns later.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        n_tests     = 0;
        n_fail      = 0;
        rst         = 1'b1;
        idle_thresh = '0;
        busy        = 1'b0;
        wake_req    = 1'b0;
        force_on    = 1'b0;
        tick(3);
        rst = 1'b0;

        // Reset values
        chk_eq("rst_clk_dis", 32'(clk_dis), 32'd0);
        chk_eq("rst_wake_ack", 32'(wake_ack), 32'd0);
        chk_eq("rst_gated", 32'(gated), 32'd0);
        chk_eq("rst_events", 32'(gate_events), 32'd0);

        // Threshold 4: gated after the 4th idle edge
        idle_thresh = 8'd4;
        tick(3);
        chk_eq("thr_not_yet", 32'(clk_dis), 32'd0);
        tick(1);
        chk_eq("thr_clk_dis", 32'(clk_dis), 32'd1);
        chk_eq("thr_gated", 32'(gated), 32'd1);
        chk_eq("thr_events", 32'(gate_events), 32'd1);

        // busy de-gates on the sampling edge; WAKE lasts 2 edges
        busy = 1'b1;
        tick(1);
        chk_eq("busy_degate", 32'(clk_dis), 32'd0);
        chk_eq("busy_ungated", 32'(gated), 32'd0);
        busy = 1'b0;
        tick(2);
        // Busy pulse mid-count restarts the idle count
        tick(2);
        busy = 1'b1;
        tick(1);
        busy = 1'b0;
        tick(3);
        chk_eq("restart_not_yet", 32'(clk_dis), 32'd0);
        tick(1);
        chk_eq("restart_gate", 32'(clk_dis), 32'd1);
        chk_eq("restart_events", 32'(gate_events), 32'd2);

        // Wake handshake from GATED
        wake_req = 1'b1;
        tick(1);
        chk_eq("wk_k_clk_dis", 32'(clk_dis), 32'd0);
        chk_eq("wk_k_ack", 32'(wake_ack), 32'd0);
        tick(2);
        chk_eq("wk_k2_ack", 32'(wake_ack), 32'd0);
        tick(1);
        chk_eq("wk_k3_ack", 32'(wake_ack), 32'd1);
        acc = 0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            acc += int'(wake_ack) + int'(clk_dis);
        end
        chk_eq("wk_no_second_ack", 32'(acc), 32'd0);
        wake_req = 1'b0;
        tick(1);
        wake_req = 1'b1;
        tick(1);
        chk_eq("wk_reraise_ack", 32'(wake_ack), 32'd1);
        tick(1);
        chk_eq("wk_ack_single", 32'(wake_ack), 32'd0);
        wake_req = 1'b0;

        // idle_thresh=0 never gates
        idle_thresh = 8'd0;
        acc = 0;
        for (int i = 0; i < 300; i++) begin
            tick(1);
            acc += int'(clk_dis);
        end
        chk_eq("thr0_no_gate", 32'(acc), 32'd0);

        // force_on de-gates and blocks re-gating while held
        idle_thresh = 8'd4;
        tick(4);
        chk_eq("force_pre_gate", 32'(clk_dis), 32'd1);
        chk_eq("force_pre_events", 32'(gate_events), 32'd3);
        force_on = 1'b1;
        tick(1);
        chk_eq("force_degate", 32'(clk_dis), 32'd0);
        acc = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            acc += int'(clk_dis);
        end
        chk_eq("force_hold", 32'(acc), 32'd0);
        force_on = 1'b0;
        tick(4);
        chk_eq("regate", 32'(clk_dis), 32'd1);
        // Zeroing the threshold while gated does not de-gate
        idle_thresh = 8'd0;
        tick(3);
        chk_eq("thr0_gated_hold", 32'(clk_dis), 32'd1);
        chk_eq("thr0_events", 32'(gate_events), 32'd4);

        // Asynchronous reset in GATED
        rst = 1'b1;
        #1;
        chk_eq("arst_g_clk_dis", 32'(clk_dis), 32'd0);
        chk_eq("arst_g_events", 32'(gate_events), 32'd0);
        chk_eq("arst_g_gated", 32'(gated), 32'd0);
        tick(1);
        rst = 1'b0;
        idle_thresh = 8'd4;
        tick(3);
        chk_eq("arst_g_run", 32'(clk_dis), 32'd0);
        tick(1);
        chk_eq("arst_g_regate", 32'(clk_dis), 32'd1);

        // Asynchronous reset in WAKE
        busy = 1'b1;
        tick(1);
        busy = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk_eq("arst_w_clk_dis", 32'(clk_dis), 32'd0);
        chk_eq("arst_w_events", 32'(gate_events), 32'd0);
        tick(1);
        rst = 1'b0;
        wake_req = 1'b1;
        tick(1);
        chk_eq("arst_w_run_ack", 32'(wake_ack), 32'd1);
        wake_req = 1'b0;
        tick(1);

        // Event counter saturation at 15 (CNT_W=4)
        idle_thresh = 8'd1;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            busy = 1'b1;
            tick(1);
            busy = 1'b0;
            tick(2);
        end
        chk_eq("sat_events", 32'(gate_events), 32'd15);

        // Lowering the threshold below the live count gates on the next idle edge
        idle_thresh = 8'd200;
        tick(50);
        chk_eq("lower_pre", 32'(clk_dis), 32'd0);
        idle_thresh = 8'd3;
        tick(1);
        chk_eq("lower_gate", 32'(clk_dis), 32'd1);
        chk_eq("lower_gated", 32'(gated), 32'd1);
        chk_eq("lower_events", 32'(gate_events), 32'd15);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
